// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide single-port RAM between icache and dcache,
// one grant per transaction, with a starvation guard for the icache.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);
    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
    localparam logic [1:0] ACCESS = 2'd2;

    state_t        state;
    logic [CW-1:0] starveCnt;
    logic          dReq, dDone, iDone;

    assign dReq  = dREN | dWEN;
    assign dDone = (state == DGNT) && dReq && (ramstate == ACCESS);
    assign iDone = (state == IGNT) && iREN && (ramstate == ACCESS);

    // A dropped request ends the grant with no completion and leaves starveCnt alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            starveCnt <= '0;
        end else begin
            case (state)
                IDLE: state <= (iREN && starveCnt == SMAX) ? IGNT : dReq ? DGNT : iREN ? IGNT : IDLE;
                DGNT: if (!dReq) state <= IDLE;
                      else if (dDone) begin
                          state     <= IDLE;
                          starveCnt <= !iREN ? '0 : (starveCnt == SMAX) ? SMAX : starveCnt + CW'(1);
                      end
                IGNT: if (!iREN) state <= IDLE;
                      else if (iDone) begin
                          state     <= IDLE;
                          starveCnt <= '0;
                      end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and data follow the granted port combinationally; nothing is latched.
    assign ramWEN   = (state == DGNT) && dWEN;
    assign ramREN   = ((state == DGNT) && dREN && !dWEN) || ((state == IGNT) && iREN);
    assign ramaddr  = (state == DGNT) ? daddr : (state == IGNT) ? iaddr : '0;
    assign ramstore = (state == DGNT) ? dstore : '0;
    assign dwait    = !dDone;
    assign iwait    = !iDone;
    assign dload    = (dDone && !dWEN) ? ramload : '0;
    assign iload    = iDone ? ramload : '0;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM controller that lets the instruction cache and the data cache share one word-wide RAM.
- Arbitrates between the two requesters and holds one grant per transaction.
- Drives RAM read and write enables, address and store data, and returns per-requester wait and load data.
- Sits between both caches and the RAM model; the caches see a wait-until-deasserted handshake.

Parameters:
- WORD_W, 32, data width of RAM words.
- ADDR_W, 32, byte address width.
- STARVE_MAX, 4, consecutive dcache grants allowed while icache waits before icache is forced next.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache address.
- iwait  out  1  icache wait; 0 only in the completion cycle.
- iload  out  WORD_W  icache read data; valid when iwait=0 in the completion cycle.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; dWEN has precedence if both dREN and dWEN are set.
- daddr  in  ADDR_W  dcache address.
- dstore  in  WORD_W  dcache write data.
- dwait  out  1  dcache wait.
- dload  out  WORD_W  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- State machine has three states: IDLE, DGNT, IGNT.
- starve_cnt is a counter of width clog2(STARVE_MAX+1).
- Reset (nRST=0, async):
  - state=IDLE, starve_cnt=0.
  - All RAM outputs 0; iload=dload=0; iwait=dwait=1.
- Wait outputs:
  - iwait=1 and dwait=1 in every cycle except a completion cycle.
  - Both are 1 in IDLE even when no request is pending.
- IDLE transitions (priority order):
  - (iREN && starve_cnt==STARVE_MAX) -> IGNT.
  - else (dREN|dWEN) -> DGNT.
  - else iREN -> IGNT.
  - else stay in IDLE.
  - No RAM enables are driven in IDLE, so every transaction has one arbitration cycle.
- DGNT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
  - When ramstate==ACCESS: dwait=0, dload=ramload (0 for writes), next state IDLE.
  - On that completion: starve_cnt increments, saturating at STARVE_MAX, if iREN=1; otherwise it clears to 0.
- IGNT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - When ramstate==ACCESS: iwait=0, iload=ramload, next state IDLE, starve_cnt=0.
- Outside completion cycles, iload and dload are 0.
- BUSY, FREE or ERROR while granted: hold the grant and keep the outputs stable. ERROR is never reported as a completion.
- Abort: if the granted requester drops its request (DGNT with dREN=dWEN=0, or IGNT with iREN=0):
  - Next state is IDLE, RAM enables are 0 that cycle, no completion, starve_cnt unchanged.
- No preemption: a new request from the other requester while a grant is held is ignored until the grant returns to IDLE.
- Requests are level-held; the arbiter never latches the address.
  - ramaddr tracks the granted requester's port combinationally.
  - The requester must hold its address and data stable until its wait drops.
- Async reset mid-transaction returns to IDLE immediately, all enables drop, starve_cnt clears.

Test Plan:
- Reset, then dREN=1, daddr=0x40, RAM gives ACCESS on the 3rd granted cycle with ramload=0xDEADBEEF:
  - 1 IDLE cycle, then ramREN=1 and ramaddr=0x40 for 3 cycles.
  - dwait=0 and dload=0xDEADBEEF in the 3rd granted cycle; back to IDLE.
- iREN and dWEN asserted together, daddr=0x80, dstore=0x12345678:
  - dcache is granted first, with ramWEN=1 and ramstore=0x12345678.
  - After completion, IDLE, then the icache grant.
- iREN held high while dREN is re-asserted after every completion, 1-cycle ACCESS:
  - Exactly 4 dcache completions, then 1 icache completion (iwait=0), then starve_cnt=0.
- IGNT with ramstate=BUSY, then iREN dropped:
  - Next cycle is IDLE, ramREN=0, iwait=1, no iload.
- ramstate=ERROR for 5 cycles during DGNT, then ACCESS:
  - dwait stays 1 through the ERROR cycles; completes once on ACCESS.
- nRST pulsed low mid-DGNT:
  - ramREN, ramWEN and ramaddr go 0 asynchronously; iwait=dwait=1.
  - A pending iREN is granted normally after reset release.
